// File: rtl/conv_pkg.sv
// Shared defaults, FSM encoding and index widths for the sequential convolution controller.
package conv_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_N      = 8;
    localparam int DEF_OUT_W  = 2 * DEF_DATA_W + $clog2(DEF_N);
    localparam int IDX_W      = $clog2(DEF_N);
    localparam int NOUT_W     = $clog2(2 * DEF_N - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_e;

endpackage

// File: rtl/conv_mac.sv
// Time-shared multiply-accumulate: one unsigned DATA_W x DATA_W product folded into a registered OUT_W sum.
module conv_mac #(
    parameter int DATA_W = 4,
    parameter int OUT_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_acc,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [OUT_W-1:0]  acc
);

    logic [2*DATA_W-1:0] prod_s;
    logic [OUT_W-1:0]    acc_d;
    logic [OUT_W-1:0]    acc_q;

    // Product is zero-extended to OUT_W; sizing guarantees the sum never wraps.
    always_comb begin
        prod_s = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        if (clr_acc) begin
            acc_d = {OUT_W{1'b0}};
        end else if (en) begin
            acc_d = acc_q + {{(OUT_W-2*DATA_W){1'b0}}, prod_s};
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {OUT_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequential 2N-1 output linear convolver: loads x/h pairs, accumulates each y[n] over its valid k range, streams results.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int   DATA_W = DEF_DATA_W,
    parameter int   N      = DEF_N,
    localparam int  OUT_W  = 2 * DATA_W + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_h,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int IW = $clog2(N);
    localparam int NW = $clog2(2 * N - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [IW-1:0]     k_q, k_d;
    logic [NW-1:0]     n_q, n_d;
    logic [DATA_W-1:0] x_q [N];
    logic [DATA_W-1:0] h_q [N];
    logic              in_ready_q, out_valid_q, out_last_q, busy_q;

    logic              load_we_s, clr_acc_s, mac_en_s;
    logic [IW-1:0]     kmax_s, kmin_next_s, hidx_s;
    logic [NW-1:0]     n_inc_s;
    logic [OUT_W-1:0]  acc_s;

    // k window for the current output and the start of the next one.
    always_comb begin
        n_inc_s     = n_q + {{(NW-1){1'b0}}, 1'b1};
        kmax_s      = (n_q < NW'(N)) ? n_q[IW-1:0] : IW'(N - 1);
        kmin_next_s = (n_inc_s >= NW'(N)) ? IW'(n_inc_s - NW'(N - 1)) : {IW{1'b0}};
        hidx_s      = n_q[IW-1:0] - k_q;
    end

    // Next-state and datapath control; clr overrides every handshake.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        k_d       = k_q;
        n_d       = n_q;
        load_we_s = 1'b0;
        clr_acc_s = 1'b0;
        mac_en_s  = 1'b0;
        if (clr) begin
            state_d   = LOAD;
            i_d       = {IW{1'b0}};
            k_d       = {IW{1'b0}};
            n_d       = {NW{1'b0}};
            clr_acc_s = 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        load_we_s = 1'b1;
                        if (i_q == IW'(N - 1)) begin
                            state_d   = CALC;
                            i_d       = {IW{1'b0}};
                            k_d       = {IW{1'b0}};
                            n_d       = {NW{1'b0}};
                            clr_acc_s = 1'b1;
                        end else begin
                            i_d = i_q + {{(IW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
                CALC: begin
                    mac_en_s = 1'b1;
                    if (k_q == kmax_s) begin
                        state_d = EMIT;
                    end else begin
                        k_d = k_q + {{(IW-1){1'b0}}, 1'b1};
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        clr_acc_s = 1'b1;
                        if (n_q == NW'(2 * N - 2)) begin
                            state_d = LOAD;
                            n_d     = {NW{1'b0}};
                            k_d     = {IW{1'b0}};
                        end else begin
                            state_d = CALC;
                            n_d     = n_inc_s;
                            k_d     = kmin_next_s;
                        end
                    end else begin
                        state_d = EMIT;
                    end
                end
                default: begin
                    state_d   = LOAD;
                    i_d       = {IW{1'b0}};
                    k_d       = {IW{1'b0}};
                    n_d       = {NW{1'b0}};
                    clr_acc_s = 1'b1;
                end
            endcase
        end
    end

    // State, indices and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            i_q         <= {IW{1'b0}};
            k_q         <= {IW{1'b0}};
            n_q         <= {NW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            k_q         <= k_d;
            n_q         <= n_d;
            in_ready_q  <= (state_d == LOAD);
            out_valid_q <= (state_d == EMIT);
            out_last_q  <= (state_d == EMIT) && (n_d == NW'(2 * N - 2));
            busy_q      <= (state_d == CALC) || (state_d == EMIT);
        end
    end

    // Sample register files; clr leaves contents to be overwritten by the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N; j++) begin
                x_q[j] <= {DATA_W{1'b0}};
                h_q[j] <= {DATA_W{1'b0}};
            end
        end else if (load_we_s) begin
            x_q[i_q] <= in_x;
            h_q[i_q] <= in_h;
        end else begin
            x_q[i_q] <= x_q[i_q];
            h_q[i_q] <= h_q[i_q];
        end
    end

    conv_mac #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_acc (clr_acc_s),
        .en      (mac_en_s),
        .a       (x_q[k_q]),
        .b       (h_q[hidx_s]),
        .acc     (acc_s)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign out_data  = acc_s;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Randomized self-checking bench for conv_seq_ctrl against a direct double-sum convolution model.
module tb_conv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [3:0]  in_x, in_h;
    logic [10:0] out_data;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  xv [8];
    logic [3:0]  hv [8];
    int          exp_y [15];

    conv_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_h      (in_h),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_model();
        for (int n = 0; n < 15; n++) begin
            exp_y[n] = 0;
            for (int k = 0; k < 8; k++)
                if (n - k >= 0 && n - k < 8)
                    exp_y[n] += int'(xv[k]) * int'(hv[n - k]);
        end
    endfunction

    function automatic logic pick_ready(input int mode, input int j);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (j % 4 == 0) || (j % 4 == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic rand_vecs();
        for (int k = 0; k < 8; k++) begin
            xv[k] = 4'($urandom);
            hv[k] = 4'($urandom);
        end
    endtask

    task automatic load_frame(output int t_last);
        ref_model();
        for (int idx = 0; idx < 8; idx++) begin
            int  guard = 0;
            bit  sent  = 0;
            while (!sent) begin
                in_valid = (guard >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
                in_x     = in_valid ? xv[idx] : 4'($urandom);
                in_h     = in_valid ? hv[idx] : 4'($urandom);
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL load_ready idx=%0d got in_ready=%b want 1", idx, in_ready);
                end
                sent = in_valid;
                tick();
                guard++;
            end
        end
        in_valid = 1'b0;
        t_last   = cyc;
    endtask

    task automatic collect(input int mode, input int t_load, input bit chk_lat);
        int j = 0;
        for (int n = 0; n < 15; n++) begin
            int          guard   = 0;
            bit          done    = 0;
            bit          holding = 0;
            logic [10:0] held    = 11'd0;
            while (!done && guard < 60) begin
                out_ready = pick_ready(mode, j);
                in_valid  = 1'($urandom);
                in_x      = 4'($urandom);
                in_h      = 4'($urandom);
                if (out_valid === 1'b1) begin
                    if (holding) begin
                        n_cmp++;
                        if (out_data !== held) begin
                            n_err++;
                            $display("FAIL stall_stable n=%0d got %0d want %0d", n, out_data, held);
                        end
                    end
                    if (out_ready) begin
                        n_cmp++;
                        if (out_data !== 11'(exp_y[n])) begin
                            n_err++;
                            $display("FAIL y n=%0d got %0d want %0d", n, out_data, exp_y[n]);
                        end
                        n_cmp++;
                        if (out_last !== (n == 14)) begin
                            n_err++;
                            $display("FAIL out_last n=%0d got %b want %b", n, out_last, (n == 14));
                        end
                        done = 1;
                    end else begin
                        holding = 1;
                        held    = out_data;
                    end
                end else begin
                    n_cmp++;
                    if (busy !== 1'b1 || in_ready !== 1'b0) begin
                        n_err++;
                        $display("FAIL calc_flags n=%0d got busy=%b in_ready=%b want 1/0", n, busy, in_ready);
                    end
                end
                tick();
                guard++;
                j++;
            end
            if (!done) begin
                n_cmp++;
                n_err++;
                $display("FAIL timeout n=%0d got no handshake want one within 60 cycles", n);
                out_ready = 1'b0;
                in_valid  = 1'b0;
                return;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (chk_lat) begin
            n_cmp++;
            if (cyc - t_load != 79) begin
                n_err++;
                $display("FAIL latency got %0d want 79", cyc - t_load);
            end
        end
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rearm got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        end
    endtask

    task automatic run_frame(input int mode, input bit chk_lat);
        int t;
        load_frame(t);
        collect(mode, t, chk_lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_x = 4'd0; in_h = 4'd0;
        tick(); tick();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_data !== 11'd0) begin
            n_err++;
            $display("FAIL reset got rdy=%b vld=%b last=%b busy=%b data=%0d want 1/0/0/0/0",
                     in_ready, out_valid, out_last, busy, out_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ones();
        for (int k = 0; k < 8; k++) begin xv[k] = 4'd1; hv[k] = 4'd1; end
        run_frame(0, 1'b1);
    endtask

    task automatic test_max();
        for (int k = 0; k < 8; k++) begin xv[k] = 4'd15; hv[k] = 4'd15; end
        run_frame(0, 1'b1);
    endtask

    task automatic test_impulse();
        for (int k = 0; k < 8; k++) begin xv[k] = (k == 0) ? 4'd1 : 4'd0; hv[k] = 4'(k + 2); end
        run_frame(2, 1'b0);
    endtask

    task automatic test_stall();
        logic [3:0] xs [8];
        logic [3:0] hs [8];
        xs = '{4'd7, 4'd3, 4'd9, 4'd2, 4'd5, 4'd1, 4'd8, 4'd4};
        hs = '{4'd6, 4'd2, 4'd7, 4'd1, 4'd9, 4'd3, 4'd5, 4'd8};
        xv = xs;
        hv = hs;
        run_frame(1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] xs [8];
        logic [3:0] hs [8];
        xs = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd0, 4'd1};
        hs = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
        xv = xs;
        hv = hs;
        run_frame(0, 1'b1);
        rand_vecs();
        run_frame(0, 1'b1);
    endtask

    task automatic test_rst_mid_calc();
        int t;
        rand_vecs();
        load_frame(t);
        out_ready = 1'b1;
        repeat (22) tick();
        n_cmp++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pre_rst_calc got busy=%b out_valid=%b want 1/0", busy, out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 11'd0) begin
            n_err++;
            $display("FAIL rst_async got vld=%b rdy=%b busy=%b data=%0d want 0/1/0/0",
                     out_valid, in_ready, busy, out_data);
        end
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rand_vecs();
        run_frame(2, 1'b0);
    endtask

    task automatic test_clr_emit();
        int t;
        int guard = 0;
        rand_vecs();
        load_frame(t);
        out_ready = 1'b0;
        while (out_valid !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL clr_wait got out_valid=%b want 1", out_valid);
        end
        clr = 1'b1;
        out_ready = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 11'd0) begin
            n_err++;
            $display("FAIL clr_emit got rdy=%b vld=%b busy=%b data=%0d want 1/0/0/0",
                     in_ready, out_valid, busy, out_data);
        end
        rand_vecs();
        run_frame(0, 1'b1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            rand_vecs();
            run_frame(2, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_max();
        test_impulse();
        test_stall();
        test_back_to_back();
        test_rst_mid_calc();
        test_clr_emit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
